// File: rtl/pcihellocore_ledsport_ctrl_if.sv
// Avalon-MM slave bus for the LED/GPIO port controller: word address, write strobe, write data, registered read data.
interface pcihellocore_ledsport_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );
endinterface

// File: rtl/pcihellocore_ledsport_ctrl.sv
// LED/GPIO output port with set/clear, timed pulse and optional blink overlay.
// Blink hardware is compiled in only when LEDSPORT_BLINK_EN is defined.
module pcihellocore_ledsport_ctrl #(
    parameter int unsigned PULSE_CYCLES      = 1000,
    parameter int unsigned BLINK_HALF_PERIOD = 25000000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    pcihellocore_ledsport_ctrl_if.slave   bus,
    output logic [31:0]                   out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_PULSE    = 3'd2;
    localparam logic [2:0] ADDR_PCOUNT   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_BLINK    = 3'd6;

    localparam logic [15:0] PULSE_RELOAD = 16'(PULSE_CYCLES - 1);
    localparam logic [31:0] BLINK_LAST   = 32'(BLINK_HALF_PERIOD - 1);

    // Out-of-range parameters would silently truncate the counters.
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > 65535) begin : g_bad_pulse_cycles
        $error("PULSE_CYCLES out of range 1..65535");
    end
    if (BLINK_HALF_PERIOD < 1) begin : g_bad_blink_half_period
        $error("BLINK_HALF_PERIOD out of range 1..2^32-1");
    end

    logic        wr_en;
    logic [31:0] data_q, data_d;
    logic [31:0] pulse_mask_q, pulse_mask_d;
    logic [15:0] pulse_cnt_q, pulse_cnt_d;
    logic [31:0] readdata_q, readdata_d;
    logic [31:0] blink_mask;
    logic        blink_phase;

    assign wr_en = bus.chipselect && !bus.write_n;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_d = bus.writedata;
                ADDR_OUTSET:   data_d = data_q | bus.writedata;
                ADDR_OUTCLEAR: data_d = data_q & ~bus.writedata;
                default:       data_d = data_q;
            endcase
        end
    end

    // A PULSE write overrides the countdown, including on the expiry cycle.
    // Writing 0 cancels; the count is cleared too so PULSE_COUNT reads 0 when idle.
    always_comb begin
        pulse_mask_d = pulse_mask_q;
        pulse_cnt_d  = pulse_cnt_q;
        if (wr_en && bus.address == ADDR_PULSE) begin
            pulse_mask_d = bus.writedata;
            pulse_cnt_d  = (bus.writedata != 32'd0) ? PULSE_RELOAD : 16'd0;
        end else if (pulse_mask_q != 32'd0) begin
            if (pulse_cnt_q != 16'd0) begin
                pulse_cnt_d = pulse_cnt_q - 16'd1;
            end else begin
                pulse_mask_d = 32'd0;
            end
        end
    end

    always_comb begin
        readdata_d = 32'd0;
        case (bus.address)
            ADDR_DATA:   readdata_d = data_q;
            ADDR_PULSE:  readdata_d = pulse_mask_q;
            ADDR_PCOUNT: readdata_d = {16'd0, pulse_cnt_q};
            ADDR_BLINK:  readdata_d = blink_mask;
            default:     readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= 32'd0;
            pulse_mask_q <= 32'd0;
            pulse_cnt_q  <= 16'd0;
            readdata_q   <= 32'd0;
        end else begin
            data_q       <= data_d;
            pulse_mask_q <= pulse_mask_d;
            pulse_cnt_q  <= pulse_cnt_d;
            readdata_q   <= readdata_d;
        end
    end

`ifdef LEDSPORT_BLINK_EN
    logic [31:0] blink_mask_q, blink_mask_d;
    logic [31:0] presc_q, presc_d;
    logic        phase_q, phase_d;

    // The prescaler free-runs; BLINK writes only change which bits are overlaid.
    always_comb begin
        blink_mask_d = blink_mask_q;
        if (wr_en && bus.address == ADDR_BLINK) begin
            blink_mask_d = bus.writedata;
        end
        if (presc_q == BLINK_LAST) begin
            presc_d = 32'd0;
            phase_d = !phase_q;
        end else begin
            presc_d = presc_q + 32'd1;
            phase_d = phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask_q <= 32'd0;
            presc_q      <= 32'd0;
            phase_q      <= 1'b0;
        end else begin
            blink_mask_q <= blink_mask_d;
            presc_q      <= presc_d;
            phase_q      <= phase_d;
        end
    end

    assign blink_mask  = blink_mask_q;
    assign blink_phase = phase_q;
`else
    assign blink_mask  = 32'd0;
    assign blink_phase = 1'b0;
`endif

    assign bus.readdata = readdata_q;
    assign out_port     = (data_q | pulse_mask_q) ^ (blink_mask & {32{blink_phase}});

endmodule
